// File: rtl/operand_selector_if.sv
// Operand selector bus: start/mode/op request from the control FSM, manual
// key entry, matrix slot status, and the selection result returned upstream.
// master = control FSM / user-input side, slave = operand_selector.
interface operand_selector_if;
    logic        start_select;
    logic        manual_mode;
    logic [2:0]  op_sel;
    logic [3:0]  sw_id;
    logic        key_ok;
    logic        key_back;
    logic [15:0] mat_valid;
    logic [95:0] mat_dims;
    logic [3:0]  selected_a;
    logic [3:0]  selected_b;
    logic        select_done;
    logic        select_error;
    logic        busy;

    modport master (
        output start_select, manual_mode, op_sel, sw_id, key_ok, key_back,
               mat_valid, mat_dims,
        input  selected_a, selected_b, select_done, select_error, busy
    );

    modport slave (
        input  start_select, manual_mode, op_sel, sw_id, key_ok, key_back,
               mat_valid, mat_dims,
        output selected_a, selected_b, select_done, select_error, busy
    );
endinterface

// File: rtl/operand_selector.sv
// operand_selector: picks matrix IDs A/B for the operation stage.
// Manual mode takes IDs from the switches on key_ok; random mode draws slot
// IDs from a free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
// until a usable, dimension-compatible slot is found or the draw budget ends.
// Optional feature macro: OPSEL_TIMEOUT_EN adds a manual-mode idle timeout.
module operand_selector #(
    parameter int          NUM_SLOTS   = 16,
    parameter int          MAX_TRIES   = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned TIMEOUT_CYC = 32'd1_000_000_000
) (
    input  logic              clk,
    input  logic              rst,
    operand_selector_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MAN_A  = 3'd1,
        ST_MAN_B  = 3'd2,
        ST_RAND_A = 3'd3,
        ST_RAND_B = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam int               TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    // Parameter sanity, caught at elaboration
    if (NUM_SLOTS < 1 || NUM_SLOTS > 16) begin : g_bad_slots
        $error("operand_selector: NUM_SLOTS must be 1..16");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
        $error("operand_selector: MAX_TRIES must be >= 1");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("operand_selector: LFSR_SEED must be non-zero");
    end
    if (TIMEOUT_CYC == 32'd0) begin : g_bad_timeout
        $error("operand_selector: TIMEOUT_CYC must be >= 1");
    end

    // Slot i dimensions live at [6i+5:6i]: rows[5:3], cols[2:0]
    function automatic logic [5:0] slot_dims(input logic [95:0] dims, input logic [3:0] id);
        return dims[6*id +: 6];
    endfunction

    function automatic logic slot_usable(input logic [3:0] id, input logic [15:0] valid,
                                         input logic [95:0] dims);
        logic [5:0] d;
        d = slot_dims(dims, id);
        return (32'(id) < 32'(NUM_SLOTS)) && valid[id] &&
               (d[5:3] != 3'd0) && (d[5:3] <= 3'd5) &&
               (d[2:0] != 3'd0) && (d[2:0] <= 3'd5);
    endfunction

    // add needs identical shapes, multiply needs cols(A)==rows(B)
    function automatic logic dims_compatible(input logic [2:0] op, input logic [5:0] da,
                                             input logic [5:0] db);
        case (op)
            3'b001:  return da == db;
            3'b011:  return da[2:0] == db[5:3];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic op_is_binary(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b011);
    endfunction

    state_t           state_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic [2:0]       op_q;
    logic [3:0]       sel_a_q;
    logic [3:0]       sel_b_q;
    logic             done_q;
    logic             err_q;
    logic             busy_q;
    logic [TRY_W-1:0] try_q;
`ifdef OPSEL_TIMEOUT_EN
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYC - 32'd1);
    logic [31:0]      idle_q;
`endif

    logic [3:0] cand_s;
    logic [5:0] dims_a_s;
    logic       cand_use_s;
    logic       cand_cmp_s;
    logic       sw_use_s;
    logic       sw_cmp_s;
    logic       binary_s;

    assign lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign cand_s     = lfsr_q[3:0];
    assign dims_a_s   = slot_dims(bus.mat_dims, sel_a_q);
    assign cand_use_s = slot_usable(cand_s, bus.mat_valid, bus.mat_dims);
    assign cand_cmp_s = dims_compatible(op_q, dims_a_s, slot_dims(bus.mat_dims, cand_s));
    assign sw_use_s   = slot_usable(bus.sw_id, bus.mat_valid, bus.mat_dims);
    assign sw_cmp_s   = dims_compatible(op_q, dims_a_s, slot_dims(bus.mat_dims, bus.sw_id));
    assign binary_s   = op_is_binary(op_q);

    // Selection FSM with free-running LFSR; all outputs registered here.
    // The mode is carried by the MAN/RAND branch of the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_SEED;
            op_q    <= 3'd0;
            sel_a_q <= 4'd0;
            sel_b_q <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            try_q   <= '0;
`ifdef OPSEL_TIMEOUT_EN
            idle_q  <= 32'd0;
`endif
        end else begin
            lfsr_q <= lfsr_d;
            if (bus.start_select) begin
                // restart from any state; IDs keep their last values
                op_q    <= bus.op_sel;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                busy_q  <= 1'b1;
                try_q   <= '0;
`ifdef OPSEL_TIMEOUT_EN
                idle_q  <= 32'd0;
`endif
                state_q <= bus.manual_mode ? ST_MAN_A : ST_RAND_A;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        err_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                    ST_MAN_A: begin
                        if (bus.key_ok) begin
                            if (sw_use_s) begin
                                sel_a_q <= bus.sw_id;
                                if (binary_s) begin
                                    state_q <= ST_MAN_B;
`ifdef OPSEL_TIMEOUT_EN
                                    idle_q  <= 32'd0;
`endif
                                end else begin
                                    sel_b_q <= 4'd0;
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end
                        end else begin
`ifdef OPSEL_TIMEOUT_EN
                            if (bus.key_back) begin
                                idle_q <= 32'd0;
                            end else if (idle_q == IDLE_LAST) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                idle_q <= idle_q + 32'd1;
                            end
`endif
                        end
                    end
                    ST_MAN_B: begin
                        if (bus.key_back) begin
                            // stepping back wins over a simultaneous confirm
                            state_q <= ST_MAN_A;
`ifdef OPSEL_TIMEOUT_EN
                            idle_q  <= 32'd0;
`endif
                        end else if (bus.key_ok) begin
                            if (sw_use_s && sw_cmp_s) begin
                                sel_b_q <= bus.sw_id;
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end
                        end else begin
`ifdef OPSEL_TIMEOUT_EN
                            if (idle_q == IDLE_LAST) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                idle_q <= idle_q + 32'd1;
                            end
`endif
                        end
                    end
                    ST_RAND_A: begin
                        if (cand_use_s) begin
                            sel_a_q <= cand_s;
                            if (binary_s) begin
                                state_q <= ST_RAND_B;
                                try_q   <= '0;
                            end else begin
                                sel_b_q <= 4'd0;
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else if (try_q == TRY_LAST) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            try_q <= try_q + TRY_W'(1);
                        end
                    end
                    ST_RAND_B: begin
                        if (cand_use_s && cand_cmp_s) begin
                            sel_b_q <= cand_s;
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (try_q == TRY_LAST) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            try_q <= try_q + TRY_W'(1);
                        end
                    end
                    ST_DONE: begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    ST_ERR: begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.selected_a   = sel_a_q;
    assign bus.selected_b   = sel_b_q;
    assign bus.select_done  = done_q;
    assign bus.select_error = err_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_operand_selector.sv
// Self-checking bench for operand_selector: directed manual sequences plus
// randomized manual and random-mode selections checked against a reference
// that scans the LFSR sequence for the first usable/compatible slot.
module tb_operand_selector;

    localparam int          NS   = 16;
    localparam int          MT   = 64;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int unsigned TO   = 32'd100;

    logic clk = 1'b0;
    logic rst;

    operand_selector_if bus_if ();

    operand_selector #(
        .NUM_SLOTS  (NS),
        .MAX_TRIES  (MT),
        .LFSR_SEED  (SEED),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned edges   = 0;
    logic [15:0] valid_v;
    logic [95:0] dims_v;
    logic [3:0]  exp_a;
    logic [3:0]  exp_b;

    // Clock edges since reset release: the LFSR has advanced this many steps
    always @(posedge clk) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [15:0] lfsr_at(input int unsigned n);
        logic [15:0] l;
        l = SEED;
        for (int unsigned i = 0; i < n; i++) l = lfsr_step(l);
        return l;
    endfunction

    function automatic int rows_of(input logic [3:0] id);
        logic [95:0] s;
        s = dims_v >> (6 * int'(id));
        return int'(s[5:3]);
    endfunction

    function automatic int cols_of(input logic [3:0] id);
        logic [95:0] s;
        s = dims_v >> (6 * int'(id));
        return int'(s[2:0]);
    endfunction

    function automatic bit usable(input logic [3:0] id);
        return int'(id) < NS && valid_v[id] == 1'b1 &&
               rows_of(id) >= 1 && rows_of(id) <= 5 &&
               cols_of(id) >= 1 && cols_of(id) <= 5;
    endfunction

    function automatic bit is_binary(input logic [2:0] op);
        return op == 3'd1 || op == 3'd3;
    endfunction

    function automatic bit compat(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        if (op == 3'd1) return rows_of(a) == rows_of(b) && cols_of(a) == cols_of(b);
        if (op == 3'd3) return cols_of(a) == rows_of(b);
        return 1'b1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic apply_slots();
        bus_if.mat_valid = valid_v;
        bus_if.mat_dims  = dims_v;
    endtask

    task automatic set_slot(input int i, input logic [2:0] r, input logic [2:0] c);
        dims_v[6*i +: 6] = {r, c};
    endtask

    task automatic randomize_slots();
        logic [2:0] r;
        logic [2:0] c;
        valid_v = 16'($urandom | $urandom);
        for (int i = 0; i < 16; i++) begin
            r = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(1, 3));
            c = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(1, 3));
            set_slot(i, r, c);
        end
        apply_slots();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        exp_a = 4'd0;
        exp_b = 4'd0;
    endtask

    task automatic start_sel(input logic m, input logic [2:0] op);
        bus_if.manual_mode  = m;
        bus_if.op_sel       = op;
        bus_if.start_select = 1'b1;
        tick();
        bus_if.start_select = 1'b0;
    endtask

    task automatic press_ok(input logic [3:0] id);
        bus_if.sw_id  = id;
        bus_if.key_ok = 1'b1;
        tick();
        bus_if.key_ok = 1'b0;
    endtask

    task automatic press_back(input logic with_ok);
        bus_if.key_back = 1'b1;
        bus_if.key_ok   = with_ok;
        tick();
        bus_if.key_back = 1'b0;
        bus_if.key_ok   = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic d, input logic e, input logic bz);
        check_eq({tag, "_a"},    bus_if.selected_a,   a);
        check_eq({tag, "_b"},    bus_if.selected_b,   b);
        check_eq({tag, "_done"}, bus_if.select_done,  d);
        check_eq({tag, "_err"},  bus_if.select_error, e);
        check_eq({tag, "_busy"}, bus_if.busy,         bz);
    endtask

    // Random-mode selection on the current slots, checked against the LFSR scan
    task automatic run_random(input logic [2:0] op, input string tag);
        int unsigned n_s;
        logic [15:0] l;
        logic [3:0]  pa;
        logic [3:0]  pb;
        int          ka;
        int          kb;
        int          k;
        int          t;
        int          exp_t;
        bit          exp_err;
        bit          seen;
        apply_slots();
        start_sel(1'b0, op);
        check_eq({tag, "_busy0"}, bus_if.busy, 1'b1);
        check_eq({tag, "_done0"}, bus_if.select_done, 1'b0);
        n_s = edges;
        l   = lfsr_at(n_s);
        ka = -1; kb = -1; k = 0; pa = 4'd0; pb = 4'd0;
        while (ka < 0 && k < MT) begin
            if (usable(l[3:0])) begin ka = k; pa = l[3:0]; end
            l = lfsr_step(l);
            k++;
        end
        exp_err = 1'b0;
        if (ka < 0) begin
            exp_err = 1'b1;
            exp_t   = MT;
        end else begin
            exp_a = pa;
            if (!is_binary(op)) begin
                exp_b = 4'd0;
                exp_t = ka + 1;
            end else begin
                k = 0;
                while (kb < 0 && k < MT) begin
                    if (usable(l[3:0]) && compat(op, pa, l[3:0])) begin kb = k; pb = l[3:0]; end
                    l = lfsr_step(l);
                    k++;
                end
                if (kb < 0) begin
                    exp_err = 1'b1;
                    exp_t   = ka + 1 + MT;
                end else begin
                    exp_b = pb;
                    exp_t = ka + 1 + kb + 1;
                end
            end
        end
        t = 0; seen = 1'b0;
        while (!seen && t < 2 * MT + 8) begin
            tick();
            t++;
            seen = (bus_if.select_done === 1'b1) || (bus_if.select_error === 1'b1);
        end
        check_eq({tag, "_lat"}, t, exp_t);
        check_all(tag, exp_a, exp_b, !exp_err, exp_err, exp_err);
        tick();
        check_all({tag, "_after"}, exp_a, exp_b, !exp_err, 1'b0, 1'b0);
    endtask

    // Manual selection with random IDs, outcome predicted from the slot rules
    task automatic run_manual(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                              input string tag);
        bit err;
        apply_slots();
        start_sel(1'b1, op);
        press_ok(a);
        err = 1'b0;
        if (!usable(a)) begin
            err = 1'b1;
        end else begin
            exp_a = a;
            if (!is_binary(op)) begin
                exp_b = 4'd0;
            end else begin
                check_all({tag, "_mid"}, exp_a, exp_b, 1'b0, 1'b0, 1'b1);
                press_ok(b);
                if (usable(b) && compat(op, a, b)) exp_b = b;
                else err = 1'b1;
            end
        end
        check_all(tag, exp_a, exp_b, !err, err, err);
        tick();
        check_all({tag, "_after"}, exp_a, exp_b, !err, 1'b0, 1'b0);
    endtask

    initial begin
        int t;
        bit seen;
        rst = 1'b1;
        bus_if.start_select = 1'b0;
        bus_if.manual_mode  = 1'b0;
        bus_if.op_sel       = 3'd0;
        bus_if.sw_id        = 4'd0;
        bus_if.key_ok       = 1'b0;
        bus_if.key_back     = 1'b0;
        valid_v = 16'h0000;
        dims_v  = 96'd0;
        apply_slots();
        do_reset();
        check_all("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Manual add, slots 2,5,7 are 3x3
        valid_v = 16'h00A6;
        set_slot(2, 3'd3, 3'd3);
        set_slot(5, 3'd3, 3'd3);
        set_slot(7, 3'd3, 3'd3);
        set_slot(1, 3'd2, 3'd3);
        apply_slots();
        start_sel(1'b1, 3'b001);
        check_all("man_start", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        press_ok(4'd2);
        press_ok(4'd5);
        check_all("man_add", 4'd2, 4'd5, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        check_all("man_add_hold", 4'd2, 4'd5, 1'b1, 1'b0, 1'b0);

        // Manual multiply 2x3 * 2x3: incompatible -> single error pulse
        valid_v = 16'h000A;
        set_slot(3, 3'd2, 3'd3);
        apply_slots();
        start_sel(1'b1, 3'b011);
        press_ok(4'd1);
        press_ok(4'd3);
        check_all("man_mul_err", 4'd1, 4'd5, 1'b0, 1'b1, 1'b1);
        tick();
        check_all("man_mul_idle", 4'd1, 4'd5, 1'b0, 1'b0, 1'b0);

        // Unusable A ID -> error
        start_sel(1'b1, 3'b000);
        press_ok(4'd9);
        check_all("man_bad_a", 4'd1, 4'd5, 1'b0, 1'b1, 1'b1);
        tick();

        // key_back (alone and together with key_ok) then re-entry
        valid_v = 16'h00A6;
        apply_slots();
        start_sel(1'b1, 3'b001);
        press_ok(4'd2);
        press_back(1'b1);
        check_all("man_back_wins", 4'd2, 4'd5, 1'b0, 1'b0, 1'b1);
        press_ok(4'd5);
        press_back(1'b0);
        check_all("man_back", 4'd5, 4'd5, 1'b0, 1'b0, 1'b1);
        press_ok(4'd5);
        press_ok(4'd7);
        check_all("man_reentry", 4'd5, 4'd7, 1'b1, 1'b0, 1'b0);
        exp_a = 4'd5;
        exp_b = 4'd7;

        // Random unary on a single valid slot
        valid_v = 16'h0010;
        set_slot(4, 3'd2, 3'd2);
        run_random(3'b000, "rand_unary");
        check_eq("rand_unary_id", bus_if.selected_a, 4'd4);

        // Random add with nothing valid -> error after exactly MT draws
        valid_v = 16'h0000;
        run_random(3'b001, "rand_empty");

        // Restart in the middle of RAND_A
        apply_slots();
        start_sel(1'b0, 3'b001);
        repeat (10) tick();
        check_all("rand_stuck", exp_a, exp_b, 1'b0, 1'b0, 1'b1);
        valid_v = 16'h0010;
        run_random(3'b100, "rand_restart");

        // Randomized random-mode and manual selections
        for (int i = 0; i < 30; i++) begin
            randomize_slots();
            run_random(3'($urandom_range(0, 7)), $sformatf("rand%0d", i));
        end
        for (int i = 0; i < 20; i++) begin
            randomize_slots();
            run_manual(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), $sformatf("man%0d", i));
        end

        // Reset during MAN_B and during RAND_A
        valid_v = 16'h00A6;
        apply_slots();
        start_sel(1'b1, 3'b001);
        press_ok(4'd2);
        rst = 1'b1;
        tick();
        check_all("rst_man_b", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        valid_v = 16'h0000;
        apply_slots();
        start_sel(1'b0, 3'b000);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_all("rst_rand_a", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Manual idle: timeout only when the feature is compiled in
        start_sel(1'b1, 3'b000);
        t = 0; seen = 1'b0;
        while (!seen && t < 150) begin
            tick();
            t++;
            seen = (bus_if.select_error === 1'b1);
        end
`ifdef OPSEL_TIMEOUT_EN
        check_eq("timeout_cycle", t, TO);
        check_eq("timeout_err", bus_if.select_error, 1'b1);
        tick();
        check_eq("timeout_idle", bus_if.busy, 1'b0);
`else
        check_eq("no_timeout_err", seen, 1'b0);
        check_eq("no_timeout_busy", bus_if.busy, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
